// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// write-back, combinational ALU decode, and a retired-instruction counter.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);
  localparam logic [3:0] FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,
                         MEMRD   = 4'd3,  MEMWB   = 4'd4,  MEMWR  = 4'd5,
                         RTYPEEX = 4'd6,  RTYPEWB = 4'd7,  BEQEX  = 4'd8,
                         ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX    = 4'd11;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW   = 6'b101011,
                         OP_RT = 6'b000000, OP_BEQ  = 6'b000100,
                         OP_J  = 6'b000010, OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  logic [3:0] cur, nxt;
  ctrl_t      c;
  logic       legal_op, retire;

  always_ff @(posedge clk or negedge reset)
    if (!reset) cur <= FETCH;
    else        cur <= nxt;

  always_comb begin
    legal_op = 1'b1;
    case (op)
      OP_LW, OP_SW, OP_RT, OP_BEQ, OP_J, OP_ADDI: legal_op = 1'b1;
      default:                                    legal_op = 1'b0;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RT:        nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // An unknown opcode retires as a NOP straight out of DECODE.
  always_comb begin
    retire = 1'b0;
    case (cur)
      MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX: retire = 1'b1;
      DECODE:                                    retire = !legal_op;
      default:                                   retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;

  always_comb begin
    c = '0;
    case (cur)
      FETCH:   begin c.irwrite = 1'b1; c.alusrcb = 2'b01; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BEQEX:   begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1;
      end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
  end

  // Write strobes are gated by reset so nothing commits while it is held.
  assign pcen     = reset & (c.pcwrite | (c.branch & zero));
  assign irwrite  = reset & c.irwrite;
  assign regwrite = reset & c.regwrite;
  assign memwrite = reset & c.memwrite;
  assign iord     = c.iord;
  assign regdst   = c.regdst;
  assign memtoreg = c.memtoreg;
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign pcsrc    = c.pcsrc;
  assign state    = cur;

  always_comb begin
    alucontrol = 3'b010;
    case (c.aluop)
      2'b01: alucontrol = 3'b110;
      2'b10:
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      default: alucontrol = 3'b010;
    endcase
  end
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares state, controls and instret.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [3:0] instret;

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [3:0]  ir;
    int          tag;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         tag   = 0;
  logic [3:0] exp_ir = 4'd0;
  bit         done = 1'b0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000,
                         ILL = 6'b111111;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] expc(logic [3:0] st, logic [5:0] f, logic z, logic rn);
    logic pc_, io, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    {pc_, io, mw, irw, rd, m2r, rw, asa} = '0;
    asb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      4'd0:  begin pc_ = rn; irw = rn; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin
        asa = 1'b1;
        case (f)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b000;
        endcase
      end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; ps = 2'b01; alu = 3'b110; pc_ = z; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pc_ = 1'b1; end
      default: ;
    endcase
    return {pc_, io, mw, irw, rd, m2r, rw, asa, asb, ps, alu};
  endfunction

  function automatic void chk(string name, int t, logic [14:0] act, logic [14:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc%0d got=%h want=%h", name, t, act, want);
    end
  endfunction

  // Monitor: one expectation per presented cycle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", e.tag, {11'd0, state}, {11'd0, e.st});
        chk("ctrl", e.tag,
            {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, alucontrol}, e.ctl);
        chk("instret", e.tag, {11'd0, instret}, {11'd0, e.ir});
      end
    end
  end

  task automatic push(logic [3:0] st, logic [14:0] ctl);
    exp_t e;
    e.st = st; e.ctl = ctl; e.ir = exp_ir; e.tag = tag++;
    q.push_back(e);
  endtask

  task automatic rcyc();
    @(posedge clk); #1;
    reset = 1'b0; exp_ir = 4'd0;
    push(4'd0, expc(4'd0, funct, zero, 1'b0));
  endtask

  // seq[4*i +: 4] is the state expected in cycle i; rel releases reset in cycle 0.
  task automatic run(logic [5:0] o, logic [5:0] f, logic z, logic [19:0] seq, int n, bit rel);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rel && i == 0) reset = 1'b1;
      op = o; funct = f; zero = z;
      push(seq[i*4 +: 4], expc(seq[i*4 +: 4], f, z, 1'b1));
    end
    exp_ir = exp_ir + 4'd1;
  endtask

  initial begin
    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0;
    #2 reset = 1'b0;
    repeat (3) rcyc();
    run(LW, 6'd0, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, 1'b1);
    run(SW, 6'd0, 1'b0, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b100000, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b100010, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b100100, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b100101, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b101010, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(RT, 6'b111111, 1'b0, {8'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4, 1'b0);
    run(BEQ, 6'd0, 1'b1, {8'd0, 4'd8, 4'd1, 4'd0}, 3, 1'b0);
    run(BEQ, 6'd0, 1'b0, {8'd0, 4'd8, 4'd1, 4'd0}, 3, 1'b0);
    run(J, 6'd0, 1'b0, {8'd0, 4'd11, 4'd1, 4'd0}, 3, 1'b0);
    run(ADDI, 6'd0, 1'b0, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}, 4, 1'b0);
    run(ILL, 6'd0, 1'b0, {12'd0, 4'd1, 4'd0}, 2, 1'b0);

    // Abort an lw in MEMRD: state must drop to FETCH without a clock edge.
    @(posedge clk); #1; op = LW; push(4'd0, expc(4'd0, funct, zero, 1'b1));
    @(posedge clk); #1; push(4'd1, expc(4'd1, funct, zero, 1'b1));
    @(posedge clk); #1; push(4'd2, expc(4'd2, funct, zero, 1'b1));
    @(posedge clk); #1; push(4'd3, expc(4'd3, funct, zero, 1'b1));
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_state", -1, {11'd0, state}, 15'd0);
    chk("async_strobes", -1, {11'd0, regwrite, memwrite, pcen, irwrite}, 15'd0);
    rcyc();

    run(LW, 6'd0, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, 1'b1);
    for (int k = 0; k < 16; k++)
      run(ILL, 6'd0, 1'b0, {12'd0, 4'd1, 4'd0}, 2, 1'b0);
    @(posedge clk); #1; op = J; push(4'd0, expc(4'd0, funct, zero, 1'b1));

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", -1, 15'(q.size()), 15'd0);
    chk("wrap_instret", -1, {11'd0, instret}, 15'd1);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
